// File: rtl/dcache_ram_if.sv
// Memory-side bridge for dcache: 4-word line refills and buffered dirty-line writebacks over req/gnt/rvalid.
// Optional DCACHE_RAM_IF_FWD_EN: a refill of the buffered writeback line is served from the buffer.
module dcache_ram_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ram_rd_req_i,
  input  logic [ADDR_W-1:0]            ram_rd_addr_i,
  output logic                         ram_rd_rdy_o,
  output logic [DATA_W-1:0]            ram_rd_data_o,
  output logic [2:0]                   ram_rd_num_o,
  input  logic                         ram_wr_req_i,
  input  logic [ADDR_W-1:0]            ram_wr_addr_i,
  input  logic [LINE_WORDS*DATA_W-1:0] ram_wr_data_i,
  input  logic                         ram_dirty_i,
  output logic                         ram_wr_rdy_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i
);
  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = CNT_W + 2;
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, WB, RD_REQ, RD_WAIT
`ifdef DCACHE_RAM_IF_FWD_EN
    , FWD
`endif
  } state_t;

  state_t                             state_q, state_d;
  logic                               buf_vld;
  logic [LINE_W-1:0]                  buf_line, rd_line;
  logic [LINE_WORDS-1:0][DATA_W-1:0]  buf_data;
  logic [CNT_W-1:0]                   wcnt, rcnt;
  logic                               rd_rdy_q;
  logic [DATA_W-1:0]                  rd_data_q;
  logic [2:0]                         rd_num_q;
  logic                               wr_acc, rd_done;
  logic                               unused_addr_bits;

  assign wr_acc = ram_wr_req_i & ~buf_vld & ram_dirty_i;
  // The request line is still held during the last-beat pulse; don't mistake it for a new refill.
  assign rd_done = rd_rdy_q & (rd_num_q == 3'(LINE_WORDS));
  assign unused_addr_bits = ^{ram_rd_addr_i[OFF_W-1:0], ram_wr_addr_i[OFF_W-1:0]};

`ifdef DCACHE_RAM_IF_FWD_EN
  logic fwd_hit;
  assign fwd_hit = buf_vld & (ram_rd_addr_i[ADDR_W-1:OFF_W] == buf_line);
`endif

  assign ram_wr_rdy_o  = ~buf_vld;
  assign ram_rd_rdy_o  = rd_rdy_q;
  assign ram_rd_data_o = rd_data_q;
  assign ram_rd_num_o  = rd_num_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: if (!rd_done) begin
`ifdef DCACHE_RAM_IF_FWD_EN
        if (ram_rd_req_i && fwd_hit) state_d = FWD;
        else
`endif
        if (buf_vld)           state_d = WB;
        else if (ram_rd_req_i) state_d = RD_REQ;
      end
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {buf_line, wcnt, 2'b00};
        mem_wdata_o = buf_data[wcnt];
        if (mem_gnt_i && wcnt == LAST) state_d = IDLE;
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {rd_line, rcnt, 2'b00};
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: if (mem_rvalid_i) state_d = (rcnt == LAST) ? IDLE : RD_REQ;
`ifdef DCACHE_RAM_IF_FWD_EN
      FWD: if (rcnt == LAST) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld   <= 1'b0;
      buf_line  <= '0;
      buf_data  <= '0;
      rd_line   <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      rd_rdy_q  <= 1'b0;
      rd_data_q <= '0;
      rd_num_q  <= '0;
    end else begin
      rd_rdy_q <= 1'b0;
      if (wr_acc) begin
        buf_vld  <= 1'b1;
        buf_line <= ram_wr_addr_i[ADDR_W-1:OFF_W];
        buf_data <= ram_wr_data_i;
      end
      case (state_q)
        IDLE: if (state_d == RD_REQ) rd_line <= ram_rd_addr_i[ADDR_W-1:OFF_W];
        WB: if (mem_gnt_i) begin
          wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
          if (wcnt == LAST) buf_vld <= 1'b0;
        end
        RD_WAIT: if (mem_rvalid_i) begin
          rd_rdy_q  <= 1'b1;
          rd_data_q <= mem_rdata_i;
          rd_num_q  <= 3'(rcnt) + 3'd1;
          rcnt      <= (rcnt == LAST) ? '0 : rcnt + 1'b1;
        end
`ifdef DCACHE_RAM_IF_FWD_EN
        FWD: begin
          rd_rdy_q  <= 1'b1;
          rd_data_q <= buf_data[rcnt];
          rd_num_q  <= 3'(rcnt) + 3'd1;
          rcnt      <= (rcnt == LAST) ? '0 : rcnt + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ram_if.sv
// Directed bench for dcache_ram_if: refill, writeback, clean drop, ordering, stall/reset, optional forwarding.
module tb_dcache_ram_if;
  logic         clk = 1'b0;
  logic         rst;
  logic         ram_rd_req_i;
  logic [31:0]  ram_rd_addr_i;
  logic         ram_rd_rdy_o;
  logic [31:0]  ram_rd_data_o;
  logic [2:0]   ram_rd_num_o;
  logic         ram_wr_req_i;
  logic [31:0]  ram_wr_addr_i;
  logic [127:0] ram_wr_data_i;
  logic         ram_dirty_i;
  logic         ram_wr_rdy_o;
  logic         mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic         mem_gnt_i, mem_rvalid_i;
  logic [31:0]  mem_rdata_i;

  always #5 clk = ~clk;

  dcache_ram_if dut (
    .clk(clk), .rst(rst),
    .ram_rd_req_i(ram_rd_req_i), .ram_rd_addr_i(ram_rd_addr_i), .ram_rd_rdy_o(ram_rd_rdy_o),
    .ram_rd_data_o(ram_rd_data_o), .ram_rd_num_o(ram_rd_num_o),
    .ram_wr_req_i(ram_wr_req_i), .ram_wr_addr_i(ram_wr_addr_i), .ram_wr_data_i(ram_wr_data_i),
    .ram_dirty_i(ram_dirty_i), .ram_wr_rdy_o(ram_wr_rdy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // memory model: grant same cycle, read data one cycle later, data = addr ^ C0DE0000
  logic        gnt_en  = 1'b1;
  logic        rv_hold = 1'b0;
  logic        pend    = 1'b0;
  logic [31:0] pa      = '0;
  assign mem_gnt_i    = mem_req_o & gnt_en;
  assign mem_rvalid_i = pend & ~rv_hold;
  assign mem_rdata_i  = pa ^ 32'hC0DE_0000;

  logic        mw_q[$];
  logic [31:0] ma_q[$], md_q[$], bd_q[$];
  logic [2:0]  bn_q[$];

  always @(posedge clk) begin
    if (mem_rvalid_i) pend <= 1'b0;
    if (mem_req_o && mem_gnt_i) begin
      mw_q.push_back(mem_we_o);
      ma_q.push_back(mem_addr_o);
      md_q.push_back(mem_wdata_o);
      if (!mem_we_o) begin
        pend <= 1'b1;
        pa   <= mem_addr_o;
      end
    end
    if (ram_rd_rdy_o) begin
      bd_q.push_back(ram_rd_data_o);
      bn_q.push_back(ram_rd_num_o);
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    mw_q.delete(); ma_q.delete(); md_q.delete(); bd_q.delete(); bn_q.delete();
  endtask

  task automatic wait_last(input string tag);
    int k = 0;
    while (!(ram_rd_rdy_o && ram_rd_num_o == 3'd4) && k < 60) begin
      step(1);
      k++;
    end
    chk(tag, 64'(k < 60), 64'd1);
  endtask

  task automatic wait_wr_free(input string tag);
    int k = 0;
    while (!ram_wr_rdy_o && k < 60) begin
      step(1);
      k++;
    end
    chk(tag, 64'(k < 60), 64'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    ram_rd_req_i = 0; ram_rd_addr_i = '0;
    ram_wr_req_i = 0; ram_wr_addr_i = '0; ram_wr_data_i = '0; ram_dirty_i = 0;
    step(2);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_wr_rdy", 64'(ram_wr_rdy_o), 64'd1);
    chk("rst_rd_rdy", 64'(ram_rd_rdy_o), 64'd0);
    chk("rst_rd_num", 64'(ram_rd_num_o), 64'd0);
    rst = 1'b0;
    step(1);

    // refill 0x1000 (offset bits set to show they are ignored)
    clear_logs();
    ram_rd_addr_i = 32'h0000_1007; ram_rd_req_i = 1;
    wait_last("rd1_to");
    ram_rd_req_i = 0;
    step(2);
    chk("rd1_nbeat", 64'(bn_q.size()), 64'd4);
    chk("rd1_nmem", 64'(ma_q.size()), 64'd4);
    chk("rd1_num_hold", 64'(ram_rd_num_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rd1_num", 64'(bn_q[i]), 64'(i + 1));
      chk("rd1_data", 64'(bd_q[i]), 64'(32'hC0DE_1000 + 4 * i));
      chk("rd1_addr", 64'(ma_q[i]), 64'(32'h0000_1000 + 4 * i));
      chk("rd1_we", 64'(mw_q[i]), 64'd0);
    end

    // dirty writeback 0x2000
    clear_logs();
    ram_wr_addr_i = 32'h0000_2004;
    ram_wr_data_i = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    ram_dirty_i = 1; ram_wr_req_i = 1;
    step(1);
    ram_wr_req_i = 0;
    chk("wb_rdy_low", 64'(ram_wr_rdy_o), 64'd0);
    k = 0;
    while (!(mem_req_o && mem_addr_o == 32'h0000_200C) && k < 30) begin step(1); k++; end
    chk("wb_to", 64'(k < 30), 64'd1);
    chk("wb_rdy_last", 64'(ram_wr_rdy_o), 64'd0);
    step(1);
    chk("wb_rdy_back", 64'(ram_wr_rdy_o), 64'd1);
    step(1);
    chk("wb_nmem", 64'(ma_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wb_we", 64'(mw_q[i]), 64'd1);
      chk("wb_addr", 64'(ma_q[i]), 64'(32'h0000_2000 + 4 * i));
      chk("wb_data", 64'(md_q[i]), 64'(ram_wr_data_i[32*i +: 32]));
    end

    // clean writeback is dropped
    clear_logs();
    ram_wr_addr_i = 32'h0000_2800; ram_dirty_i = 0; ram_wr_req_i = 1;
    step(1);
    ram_wr_req_i = 0;
    chk("clean_rdy", 64'(ram_wr_rdy_o), 64'd1);
    step(5);
    chk("clean_nmem", 64'(ma_q.size()), 64'd0);
    chk("clean_rdy2", 64'(ram_wr_rdy_o), 64'd1);

    // writeback 0x3000 and refill 0x4000 together: refill first
    clear_logs();
    ram_wr_addr_i = 32'h0000_3000;
    ram_wr_data_i = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    ram_dirty_i = 1; ram_wr_req_i = 1;
    ram_rd_addr_i = 32'h0000_4000; ram_rd_req_i = 1;
    step(1);
    ram_wr_req_i = 0;
    chk("ord_rdy_low", 64'(ram_wr_rdy_o), 64'd0);
    wait_last("ord_rd_to");
    ram_rd_req_i = 0;
    step(1);
    wait_wr_free("ord_wb_to");
    step(1);
    chk("ord_nmem", 64'(ma_q.size()), 64'd8);
    chk("ord_nbeat", 64'(bd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ord_rd_we", 64'(mw_q[i]), 64'd0);
      chk("ord_rd_addr", 64'(ma_q[i]), 64'(32'h0000_4000 + 4 * i));
      chk("ord_rd_data", 64'(bd_q[i]), 64'(32'hC0DE_4000 + 4 * i));
      chk("ord_wb_we", 64'(mw_q[4 + i]), 64'd1);
      chk("ord_wb_addr", 64'(ma_q[4 + i]), 64'(32'h0000_3000 + 4 * i));
      chk("ord_wb_data", 64'(md_q[4 + i]), 64'(32'h3000_0000 + i));
    end

    // grant stall then reset while waiting for rvalid
    clear_logs();
    gnt_en = 0;
    ram_rd_addr_i = 32'h0000_6000; ram_rd_req_i = 1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 64'(mem_req_o), 64'd1);
      chk("stall_we", 64'(mem_we_o), 64'd0);
      chk("stall_addr", 64'(mem_addr_o), 64'h6000);
      step(1);
    end
    rv_hold = 1; gnt_en = 1;
    step(1);
    chk("stall_granted", 64'(ma_q.size()), 64'd1);
    rst = 1; ram_rd_req_i = 0;
    step(1);
    rst = 0;
    chk("rstw_req", 64'(mem_req_o), 64'd0);
    chk("rstw_rd_rdy", 64'(ram_rd_rdy_o), 64'd0);
    rv_hold = 0;
    step(3);
    chk("rstw_nbeat", 64'(bn_q.size()), 64'd0);
    chk("rstw_req2", 64'(mem_req_o), 64'd0);
    chk("rstw_wr_rdy", 64'(ram_wr_rdy_o), 64'd1);

`ifdef DCACHE_RAM_IF_FWD_EN
    // writeback 0x5000 accepted during refill 0x7000, then refill 0x5000 forwarded
    clear_logs();
    ram_rd_addr_i = 32'h0000_7000; ram_rd_req_i = 1;
    step(1);
    ram_wr_addr_i = 32'h0000_5000;
    ram_wr_data_i = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
    ram_dirty_i = 1; ram_wr_req_i = 1;
    step(1);
    ram_wr_req_i = 0;
    wait_last("fwd_pre_to");
    ram_rd_addr_i = 32'h0000_5000;
    step(1);
    wait_last("fwd_to");
    ram_rd_req_i = 0;
    step(1);
    wait_wr_free("fwd_wb_to");
    step(1);
    chk("fwd_nbeat", 64'(bd_q.size()), 64'd8);
    chk("fwd_nmem", 64'(ma_q.size()), 64'd8);
    for (int i = 0; i < 4; i++) begin
      chk("fwd_pre_we", 64'(mw_q[i]), 64'd0);
      chk("fwd_data", 64'(bd_q[4 + i]), 64'(32'h5000_0000 + i));
      chk("fwd_num", 64'(bn_q[4 + i]), 64'(i + 1));
      chk("fwd_wb_we", 64'(mw_q[4 + i]), 64'd1);
      chk("fwd_wb_addr", 64'(ma_q[4 + i]), 64'(32'h0000_5000 + 4 * i));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
